// File: rtl/fp32_to_int32_conv.sv
// FP32 -> signed int32 converter with an iterative shifter (SHIFT_STEP bits per cycle).
// Optional macro FP2INT_ROUND_EN selects round-to-nearest-even instead of truncation.
module fp32_to_int32_conv #(
    parameter int SHIFT_STEP = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_overflow,
    output logic        out_invalid
);

    // Handshake: a transfer happens on a rising edge where valid & ready are both high;
    // in_ready is high only in IDLE and out_valid holds with stable data until out_ready.

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [4:0] STEP = 5'(SHIFT_STEP);

    state_t state, state_next;

    logic              in_sign;
    logic [7:0]        in_exp;
    logic [22:0]       in_mant;
    logic signed [8:0] e;
    logic              is_nan, is_inf, is_big, is_small, is_special;
    logic              k_left;
    logic [4:0]        k;
    logic [31:0]       sat_val;

    logic              sign;
    logic              left;
    logic [4:0]        rem;
    logic [31:0]       mag;
    logic [4:0]        step;
    logic [31:0]       mag_shifted;
    logic [31:0]       mag_final;

`ifdef FP2INT_ROUND_EN
    logic              guard, sticky;
    logic              guard_next, sticky_next;
    logic [31:0]       lost_mask;
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_comb begin
        in_sign    = in_data[31];
        in_exp     = in_data[30:23];
        in_mant    = in_data[22:0];
        e          = $signed({1'b0, in_exp}) - 9'sd127;
        is_nan     = (in_exp == 8'hFF) && (in_mant != 23'd0);
        is_inf     = (in_exp == 8'hFF) && (in_mant == 23'd0);
        is_big     = (in_exp != 8'hFF) && (e >= 9'sd31);
        is_small   = (e < 9'sd0);
        is_special = is_nan || is_inf || is_big || is_small;
        k_left     = (e >= 9'sd23);
        k          = k_left ? 5'(e - 9'sd23) : 5'(9'sd23 - e);
        sat_val    = in_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end

    always_comb begin
        step        = (rem < STEP) ? rem : STEP;
        mag_shifted = left ? (mag << step) : (mag >> step);
`ifdef FP2INT_ROUND_EN
        // guard is the most recent bit shifted out; earlier lost bits fold into sticky
        lost_mask   = (32'd1 << step) - 32'd1;
        guard_next  = guard;
        sticky_next = sticky;
        if (!left && (step != 5'd0)) begin
            guard_next  = |(mag & (32'd1 << (step - 5'd1)));
            sticky_next = sticky | guard | (|(mag & (lost_mask >> 1)));
        end
        mag_final   = mag + {31'd0, guard & (sticky | mag[0])};
`else
        mag_final   = mag;
`endif
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = is_special ? DONE : SHIFT;
            SHIFT:   if (rem == 5'd0) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign         <= 1'b0;
            left         <= 1'b0;
            rem          <= 5'd0;
            mag          <= 32'd0;
            out_data     <= 32'd0;
            out_overflow <= 1'b0;
            out_invalid  <= 1'b0;
`ifdef FP2INT_ROUND_EN
            guard        <= 1'b0;
            sticky       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    sign         <= in_sign;
                    out_overflow <= 1'b0;
                    out_invalid  <= 1'b0;
`ifdef FP2INT_ROUND_EN
                    guard        <= 1'b0;
                    sticky       <= 1'b0;
`endif
                    if (is_nan) begin
                        out_data    <= 32'h8000_0000;
                        out_invalid <= 1'b1;
                    end else if (is_inf) begin
                        out_data     <= sat_val;
                        out_overflow <= 1'b1;
                    end else if (is_big) begin
                        // -2^31 is the one value with e==31 that fits exactly
                        if (in_sign && (e == 9'sd31) && (in_mant == 23'd0)) begin
                            out_data <= 32'h8000_0000;
                        end else begin
                            out_data     <= sat_val;
                            out_overflow <= 1'b1;
                        end
                    end else if (is_small) begin
                        out_data <= 32'd0;
`ifdef FP2INT_ROUND_EN
                        if ((e == -9'sd1) && (in_mant != 23'd0))
                            out_data <= in_sign ? 32'hFFFF_FFFF : 32'd1;
`endif
                    end else begin
                        mag  <= {8'd0, (in_exp != 8'd0), in_mant};
                        rem  <= k;
                        left <= k_left;
                    end
                end
                SHIFT: begin
                    if (rem != 5'd0) begin
                        mag <= mag_shifted;
                        rem <= rem - step;
`ifdef FP2INT_ROUND_EN
                        guard  <= guard_next;
                        sticky <= sticky_next;
`endif
                    end else begin
                        out_data <= sign ? (32'd0 - mag_final) : mag_final;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
